integ_sched: RTL
================

INTEG_SCHED -- requirements
Module: integ_sched

Interface
REQ-001 The block SHALL have parameter PERIOD, default 1000, meaning clk cycles per integration tick (at least 4).
REQ-002 The block SHALL have parameter DT_VAL, default 16'h000A, meaning the dt word presented to the integrator.
REQ-003 The block SHALL have parameter TIMEOUT, default 64, meaning the maximum number of cycles spent in RUN.
REQ-004 The block SHALL have one clock and a synchronous, active-low reset, with ports as listed in REQ-005 and REQ-006.
REQ-005 clk  in  1  system clock; all state updates on the rising edge.
REQ-006 rst  in  1  synchronous active-low reset.
REQ-007 start  in  1  run enable; level-sensitive.
REQ-008 clear  in  1  clears error flags and resets the integrator.
REQ-009 acc_valid  in  1 / acc_ready  out  1  sample handshake.
REQ-010 acx_in, acy_in, acz_in  in  16 each  accelerometer sample.
REQ-011 int_acx, int_acy, int_acz  out  16 each  registered sample to the integrator.
REQ-012 int_dt  out  16  equals DT_VAL at all times.
REQ-013 int_enable  out  1  one-cycle launch pulse.
REQ-014 int_rst  out  1  active-high integrator reset.
REQ-015 int_bussy  in  1  integrator busy.
REQ-016 int_v, int_p  in  48 each  {z,y,x} velocity and position from the integrator.
REQ-017 res_v, res_p  out  48 each  latched results.
REQ-018 res_valid  out  1  one-cycle result strobe.
REQ-019 overrun, timeout_err  out  1 each  sticky error flags.
REQ-020 miss_cnt  out  8  saturating count of missed ticks.

Function
REQ-021 Tick counter: while start=1, count 0..PERIOD-1 and wrap; tick=1 when count==PERIOD-1; hold count at 0 while start=0.
REQ-022 FSM states SHALL be IDLE, WAIT_TICK, WAIT_SAMPLE, LAUNCH, RUN, PUBLISH, CLEAR.
REQ-023 IDLE: clear=1 -> CLEAR; else start=1 -> WAIT_TICK; clear has priority over start.
REQ-024 WAIT_TICK: start=0 -> IDLE; else tick -> WAIT_SAMPLE.
REQ-025 WAIT_SAMPLE: acc_ready=1; acc_valid=1 latches acx_in, acy_in and acz_in into int_acx, int_acy and int_acz -> LAUNCH; start=0 -> IDLE without launching.
REQ-026 acc_ready SHALL be 1 only in WAIT_SAMPLE.
REQ-027 LAUNCH: int_enable=1 for exactly this cycle -> RUN; run_cnt cleared.
REQ-028 RUN: increment run_cnt each cycle; int_bussy=0 with run_cnt>=1 -> PUBLISH; run_cnt==TIMEOUT-1 with int_bussy=1 -> set timeout_err -> CLEAR.
REQ-029 PUBLISH: capture int_v and int_p into res_v and res_p; res_valid=1 for this cycle only; next state WAIT_TICK if start=1, else IDLE.
REQ-030 CLEAR: int_rst=1 for 2 cycles -> IDLE; start is ignored while in CLEAR.
REQ-031 A tick while in WAIT_SAMPLE, LAUNCH, RUN, PUBLISH or CLEAR SHALL set overrun and increment miss_cnt, saturating at 255; the missed tick is not queued.
REQ-032 start falling during LAUNCH or RUN SHALL let the current integration complete through PUBLISH, then go to IDLE.
REQ-033 clear=1 in any state SHALL zero overrun, timeout_err and miss_cnt on the next edge; only in IDLE does clear cause a CLEAR transition.
REQ-034 If a tick and timeout_err being set occur in the same cycle, both overrun and timeout_err SHALL be set.
REQ-035 res_v and res_p SHALL hold their values until the next PUBLISH.

Reset
REQ-036 rst=0 at an edge SHALL force, on that edge: state IDLE, tick counter 0, run_cnt 0, int_acx/int_acy/int_acz 0, res_v/res_p 0, int_enable 0, res_valid 0, acc_ready 0, overrun 0, timeout_err 0, miss_cnt 0, int_rst 1.
REQ-037 int_rst SHALL deassert on the first edge with rst=1.
REQ-038 rst=0 mid-RUN or mid-CLEAR SHALL abort the operation; no res_valid pulse is produced.

Verification (PERIOD=16, TIMEOUT=8)
REQ-039 The bench SHALL cover: rst=0 for 3 cycles -> all outputs 0 except int_rst=1 and int_dt=16'h000A.
REQ-040 The bench SHALL cover: start=1, acc_valid=1 with 16'h00AA/16'h007A/16'h003A at the first tick, int_bussy high 4 cycles -> one int_enable pulse, int_acx=16'h00AA, one res_valid pulse whose res_p equals the model's int_p.
REQ-041 The bench SHALL cover: acc_valid held 0 for 20 cycles after a tick -> overrun=1 and miss_cnt=1 at the next tick; then acc_valid=1 -> normal launch.
REQ-042 The bench SHALL cover: int_bussy stuck at 1 -> timeout_err=1 after 8 RUN cycles, int_rst high exactly 2 cycles, then IDLE, with no res_valid pulse.
REQ-043 The bench SHALL cover: miss_cnt driven to 255 with further missed ticks -> miss_cnt stays 255; then clear=1 -> overrun, timeout_err and miss_cnt are 0 next cycle.
REQ-044 The bench SHALL cover: rst=0 for 1 cycle during RUN -> IDLE on the next edge, res_p unchanged from reset (0), res_valid never asserted.

Source files
------------

// File: rtl/integ_sched.sv
// integ_sched: paces an external integrator with periodic ticks, hands it one
// accelerometer sample per tick, and publishes its velocity/position results.
module integ_sched #(
    parameter int          PERIOD  = 1000,
    parameter logic [15:0] DT_VAL  = 16'h000A,
    parameter int          TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        clear,
    input  logic        acc_valid,
    output logic        acc_ready,
    input  logic [15:0] acx_in,
    input  logic [15:0] acy_in,
    input  logic [15:0] acz_in,
    output logic [15:0] int_acx,
    output logic [15:0] int_acy,
    output logic [15:0] int_acz,
    output logic [15:0] int_dt,
    output logic        int_enable,
    output logic        int_rst,
    input  logic        int_bussy,
    input  logic [47:0] int_v,
    input  logic [47:0] int_p,
    output logic [47:0] res_v,
    output logic [47:0] res_p,
    output logic        res_valid,
    output logic        overrun,
    output logic        timeout_err,
    output logic [7:0]  miss_cnt
);
    localparam int CW = $clog2(PERIOD);
    localparam int RW = $clog2(TIMEOUT);

    typedef enum logic [2:0] {IDLE, WAIT_TICK, WAIT_SAMPLE, LAUNCH, RUN, PUBLISH, CLEAR} state_t;

    state_t         state_q;
    logic [CW-1:0]  cnt_q;
    logic [RW-1:0]  run_cnt_q;
    logic           clr_cnt_q;
    logic [15:0]    acx_q, acy_q, acz_q;
    logic [47:0]    res_v_q, res_p_q;
    logic           acc_ready_q, int_enable_q, int_rst_q, res_valid_q;
    logic           overrun_q, timeout_q;
    logic [7:0]     miss_q;
    logic           tick;
    logic           busy_state;

    assign tick       = start && (cnt_q == CW'(PERIOD - 1));
    assign busy_state = (state_q != IDLE) && (state_q != WAIT_TICK);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            run_cnt_q    <= '0;
            clr_cnt_q    <= 1'b0;
            acx_q        <= '0;
            acy_q        <= '0;
            acz_q        <= '0;
            res_v_q      <= '0;
            res_p_q      <= '0;
            acc_ready_q  <= 1'b0;
            int_enable_q <= 1'b0;
            int_rst_q    <= 1'b1;
            res_valid_q  <= 1'b0;
            overrun_q    <= 1'b0;
            timeout_q    <= 1'b0;
            miss_q       <= '0;
        end else begin
            acc_ready_q  <= 1'b0;
            int_enable_q <= 1'b0;
            int_rst_q    <= 1'b0;
            res_valid_q  <= 1'b0;
            cnt_q        <= !start ? '0 : (tick ? '0 : cnt_q + 1'b1);
            case (state_q)
                IDLE:
                    if (clear) begin
                        state_q   <= CLEAR;
                        clr_cnt_q <= 1'b0;
                        int_rst_q <= 1'b1;
                    end else if (start) begin
                        state_q <= WAIT_TICK;
                    end
                WAIT_TICK:
                    if (!start) begin
                        state_q <= IDLE;
                    end else if (tick) begin
                        state_q     <= WAIT_SAMPLE;
                        acc_ready_q <= 1'b1;
                    end
                WAIT_SAMPLE:
                    if (!start) begin
                        state_q <= IDLE;
                    end else if (acc_valid) begin
                        acx_q        <= acx_in;
                        acy_q        <= acy_in;
                        acz_q        <= acz_in;
                        state_q      <= LAUNCH;
                        int_enable_q <= 1'b1;
                    end else begin
                        acc_ready_q <= 1'b1;
                    end
                LAUNCH: begin
                    run_cnt_q <= '0;
                    state_q   <= RUN;
                end
                RUN: begin
                    run_cnt_q <= run_cnt_q + 1'b1;
                    // results are captured on entry so res_valid and res_v/res_p appear together
                    if (!int_bussy && run_cnt_q != '0) begin
                        res_v_q     <= int_v;
                        res_p_q     <= int_p;
                        res_valid_q <= 1'b1;
                        state_q     <= PUBLISH;
                    end else if (int_bussy && run_cnt_q == RW'(TIMEOUT - 1)) begin
                        timeout_q <= 1'b1;
                        clr_cnt_q <= 1'b0;
                        int_rst_q <= 1'b1;
                        state_q   <= CLEAR;
                    end
                end
                PUBLISH:
                    state_q <= start ? WAIT_TICK : IDLE;
                CLEAR:
                    if (clr_cnt_q) begin
                        state_q <= IDLE;
                    end else begin
                        clr_cnt_q <= 1'b1;
                        int_rst_q <= 1'b1;
                    end
                default:
                    state_q <= IDLE;
            endcase
            if (tick && busy_state) begin
                overrun_q <= 1'b1;
                if (miss_q != 8'hFF) miss_q <= miss_q + 1'b1;
            end
            // clear wins over any flag being set in the same cycle
            if (clear) begin
                overrun_q <= 1'b0;
                timeout_q <= 1'b0;
                miss_q    <= '0;
            end
        end
    end

    assign acc_ready   = acc_ready_q;
    assign int_acx     = acx_q;
    assign int_acy     = acy_q;
    assign int_acz     = acz_q;
    assign int_dt      = DT_VAL;
    assign int_enable  = int_enable_q;
    assign int_rst     = int_rst_q;
    assign res_v       = res_v_q;
    assign res_p       = res_p_q;
    assign res_valid   = res_valid_q;
    assign overrun     = overrun_q;
    assign timeout_err = timeout_q;
    assign miss_cnt    = miss_q;
endmodule
